// File: rtl/exe_stage_mc.sv
// exe_stage_mc: execute stage with forwarding, ALU, branch adder, iterative MUL/MLA, EX/MEM register.
// Revision 1.0
`default_nettype none

module exe_stage_mc #(
  parameter int DATA_WIDTH         = 32,
  parameter int REG_ADDR_WIDTH     = 4,
  parameter int MUL_BITS_PER_CYCLE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     pc_in,
  input  logic [23:0]               signed_immediate,
  input  logic [3:0]                ex_command,
  input  logic                      imm,
  input  logic [DATA_WIDTH-1:0]     imm_val,
  input  logic [DATA_WIDTH-1:0]     val_rn_in,
  input  logic [DATA_WIDTH-1:0]     val_rm_in,
  input  logic [DATA_WIDTH-1:0]     val_ra_in,
  input  logic [1:0]                sel_src1,
  input  logic [1:0]                sel_src2,
  input  logic [1:0]                sel_src3,
  input  logic [DATA_WIDTH-1:0]     mem_stage_val,
  input  logic [DATA_WIDTH-1:0]     wb_stage_val,
  input  logic [3:0]                sr_in,
  input  logic [REG_ADDR_WIDTH-1:0] dst_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      wb_en_in,
  input  logic                      b_in,
  output logic                      stall,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     alu_res,
  output logic [3:0]                sr_out,
  output logic [DATA_WIDTH-1:0]     val_rm_out,
  output logic [DATA_WIDTH-1:0]     branch_address,
  output logic [REG_ADDR_WIDTH-1:0] dst_out,
  output logic                      mem_read_out,
  output logic                      mem_write_out,
  output logic                      wb_en_out,
  output logic                      b_out
);

  localparam int ITER  = DATA_WIDTH / MUL_BITS_PER_CYCLE;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);
  localparam int MSB = DATA_WIDTH - 1;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state, next_state;

  function automatic logic [DATA_WIDTH-1:0] fwd(input logic [1:0] sel,
                                                input logic [DATA_WIDTH-1:0] rf,
                                                input logic [DATA_WIDTH-1:0] mv,
                                                input logic [DATA_WIDTH-1:0] wv);
    case (sel)
      2'b01:   return mv;
      2'b10:   return wv;
      default: return rf;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] val1, fwd_rm, val2, ra, br_sum;
  assign val1   = fwd(sel_src1, val_rn_in, mem_stage_val, wb_stage_val);
  assign fwd_rm = fwd(sel_src2, val_rm_in, mem_stage_val, wb_stage_val);
  assign ra     = fwd(sel_src3, val_ra_in, mem_stage_val, wb_stage_val);
  assign val2   = imm ? imm_val : fwd_rm;
  assign br_sum = pc_in + DATA_WIDTH'($signed(signed_immediate));

  logic is_mul;
  assign is_mul = (ex_command == 4'b1010) || (ex_command == 4'b1011);

  // Subtraction is a + ~b + cin, so carry-out is the "no borrow" flag directly.
  logic [DATA_WIDTH-1:0] addend, res;
  logic [DATA_WIDTH:0]   sum;
  logic                  cin, arith, ovf;
  logic [3:0]            alu_flags;

  always_comb begin
    addend = val2;
    cin    = 1'b0;
    arith  = 1'b0;
    case (ex_command)
      4'b0010: arith = 1'b1;
      4'b0011: begin arith = 1'b1; cin = sr_in[2]; end
      4'b0100: begin arith = 1'b1; addend = ~val2; cin = 1'b1; end
      4'b0101: begin arith = 1'b1; addend = ~val2; cin = sr_in[2]; end
      default: ;
    endcase
    sum = {1'b0, val1} + {1'b0, addend} + {{DATA_WIDTH{1'b0}}, cin};
    ovf = (val1[MSB] == addend[MSB]) && (sum[MSB] != val1[MSB]);
    case (ex_command)
      4'b0001: res = val2;
      4'b1001: res = ~val2;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: res = sum[DATA_WIDTH-1:0];
      4'b0110: res = val1 & val2;
      4'b0111: res = val1 | val2;
      4'b1000: res = val1 ^ val2;
      default: res = '0;
    endcase
    alu_flags = {res == '0, arith ? sum[DATA_WIDTH] : sr_in[2], res[MSB], arith ? ovf : sr_in[0]};
  end

  logic [DATA_WIDTH-1:0]     mcand, mplier, acc, acc_next, partial;
  logic [CNT_W-1:0]          cnt;
  logic [DATA_WIDTH-1:0]     rm_q, br_q;
  logic [REG_ADDR_WIDTH-1:0] dst_q;
  logic [3:0]                ctrl_q;
  logic [1:0]                cv_q;

  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
    acc_next = acc + partial;
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && in_valid && is_mul) begin
          stall      = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        stall = !flush && (cnt != LAST);
        if (flush || cnt == LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      out_valid      <= 1'b0;
      alu_res        <= '0;
      sr_out         <= '0;
      val_rm_out     <= '0;
      branch_address <= '0;
      dst_out        <= '0;
      {mem_read_out, mem_write_out, wb_en_out, b_out} <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      rm_q   <= '0;
      br_q   <= '0;
      dst_q  <= '0;
      ctrl_q <= '0;
      cv_q   <= '0;
    end else begin
      state <= next_state;
      if (flush) begin
        out_valid <= 1'b0;
        {mem_read_out, mem_write_out, wb_en_out, b_out} <= '0;
      end else if (state == IDLE) begin
        out_valid <= in_valid && !is_mul;
        {mem_read_out, mem_write_out, wb_en_out, b_out} <= '0;
        if (in_valid && !is_mul) begin
          alu_res        <= res;
          sr_out         <= alu_flags;
          val_rm_out     <= fwd_rm;
          branch_address <= br_sum;
          dst_out        <= dst_in;
          {mem_read_out, mem_write_out, wb_en_out, b_out} <=
            {mem_read_in, mem_write_in, wb_en_in, b_in};
        end else if (in_valid) begin
          mcand  <= val1;
          mplier <= val2;
          acc    <= ex_command[0] ? ra : '0;
          cnt    <= '0;
          rm_q   <= fwd_rm;
          br_q   <= br_sum;
          dst_q  <= dst_in;
          ctrl_q <= {mem_read_in, mem_write_in, wb_en_in, b_in};
          cv_q   <= {sr_in[2], sr_in[0]};
        end
      end else if (cnt == LAST) begin
        out_valid      <= 1'b1;
        alu_res        <= acc_next;
        sr_out         <= {acc_next == '0, cv_q[1], acc_next[MSB], cv_q[0]};
        val_rm_out     <= rm_q;
        branch_address <= br_q;
        dst_out        <= dst_q;
        {mem_read_out, mem_write_out, wb_en_out, b_out} <= ctrl_q;
      end else begin
        acc    <= acc_next;
        mcand  <= mcand << MUL_BITS_PER_CYCLE;
        mplier <= mplier >> MUL_BITS_PER_CYCLE;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: directed scoreboard bench for exe_stage_mc.
// Revision 1.0
`default_nettype none

module tb_exe_stage_mc;

  logic        clk, rst, in_valid, in_valid1, flush, imm;
  logic [31:0] pc_in, imm_val, val_rn_in, val_rm_in, val_ra_in, mem_stage_val, wb_stage_val;
  logic [23:0] signed_immediate;
  logic [3:0]  ex_command, sr_in, dst_in;
  logic [1:0]  sel_src1, sel_src2, sel_src3;
  logic        mem_read_in, mem_write_in, wb_en_in, b_in;

  logic        stall, out_valid, mem_read_out, mem_write_out, wb_en_out, b_out;
  logic [31:0] alu_res, val_rm_out, branch_address;
  logic [3:0]  sr_out, dst_out;

  logic        stall1, out_valid1, mr1, mw1, wb1, b1;
  logic [31:0] alu_res1, rm1, br1;
  logic [3:0]  sr1, dst1;

  exe_stage_mc #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .MUL_BITS_PER_CYCLE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush), .pc_in(pc_in),
    .signed_immediate(signed_immediate), .ex_command(ex_command), .imm(imm), .imm_val(imm_val),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .val_ra_in(val_ra_in),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .sel_src3(sel_src3),
    .mem_stage_val(mem_stage_val), .wb_stage_val(wb_stage_val), .sr_in(sr_in), .dst_in(dst_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_en_in(wb_en_in), .b_in(b_in),
    .stall(stall), .out_valid(out_valid), .alu_res(alu_res), .sr_out(sr_out),
    .val_rm_out(val_rm_out), .branch_address(branch_address), .dst_out(dst_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .wb_en_out(wb_en_out), .b_out(b_out)
  );

  exe_stage_mc #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4), .MUL_BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .flush(flush), .pc_in(pc_in),
    .signed_immediate(signed_immediate), .ex_command(ex_command), .imm(imm), .imm_val(imm_val),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .val_ra_in(val_ra_in),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .sel_src3(sel_src3),
    .mem_stage_val(mem_stage_val), .wb_stage_val(wb_stage_val), .sr_in(sr_in), .dst_in(dst_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_en_in(wb_en_in), .b_in(b_in),
    .stall(stall1), .out_valid(out_valid1), .alu_res(alu_res1), .sr_out(sr1),
    .val_rm_out(rm1), .branch_address(br1), .dst_out(dst1),
    .mem_read_out(mr1), .mem_write_out(mw1), .wb_en_out(wb1), .b_out(b1)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  sr;
    logic [31:0] rm;
    logic [31:0] br;
    logic [3:0]  dst;
    logic [3:0]  ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] r, input logic [3:0] s, input logic [31:0] m,
                              input logic [31:0] b, input logic [3:0] d, input logic [3:0] c);
    exp_t e;
    e = '{res: r, sr: s, rm: m, br: b, dst: d, ctrl: c};
    return e;
  endfunction

  // Monitor: every valid EX/MEM output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      exp_t act, e;
      act = '{res: alu_res, sr: sr_out, rm: val_rm_out, br: branch_address, dst: dst_out,
              ctrl: {mem_read_out, mem_write_out, wb_en_out, b_out}};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out_valid got=%h", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL result got=%h exp=%h", act, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_valid1 = 0; flush = 0; imm = 0; pc_in = 0; imm_val = 0;
    val_rn_in = 0; val_rm_in = 0; val_ra_in = 0; mem_stage_val = 0; wb_stage_val = 0;
    signed_immediate = 0; ex_command = 0; sr_in = 0; dst_in = 0;
    sel_src1 = 0; sel_src2 = 0; sel_src3 = 0;
    mem_read_in = 0; mem_write_in = 0; wb_en_in = 0; b_in = 0;
  endtask

  task automatic run_single(input exp_t e);
    exp_q.push_back(e);
    in_valid = 1;
    #1;
    check("single_stall", {31'd0, stall}, 32'd0);
    tick();
    in_valid = 0;
  endtask

  task automatic run_mul(input exp_t e, input int want_stall);
    int n;
    exp_q.push_back(e);
    in_valid = 1;
    #1;
    n = 0;
    while (stall && n < 200) begin
      n++;
      tick();
    end
    check("mul_stall_cycles", n, want_stall);
    tick();
    in_valid = 0;
  endtask

  initial begin
    int n;
    clear_inputs();
    rst = 0;
    tick(); tick();
    rst = 1;
    #1;
    check("reset_outputs", {alu_res ^ val_rm_out ^ branch_address, 28'd0, sr_out | dst_out},
          32'd0);
    check("reset_ctrl", {26'd0, out_valid, stall, mem_read_out, mem_write_out, wb_en_out, b_out},
          32'd0);

    // ADD with Rn forwarded from MEM: 0xFFFFFFFF + 1 wraps to 0
    clear_inputs();
    ex_command = 4'b0010; val_rn_in = 5; mem_stage_val = 32'hFFFF_FFFF; sel_src1 = 2'b01;
    imm = 1; imm_val = 1; val_rm_in = 32'h22; dst_in = 3; wb_en_in = 1;
    run_single(mk(32'h0, 4'b1100, 32'h22, 32'h0, 4'd3, 4'b0010));

    clear_inputs();
    ex_command = 4'b0100; val_rn_in = 32'h8000_0000; imm = 1; imm_val = 1; dst_in = 4;
    run_single(mk(32'h7FFF_FFFF, 4'b0101, 32'h0, 32'h0, 4'd4, 4'b0000));

    clear_inputs();
    ex_command = 4'b0101; val_rn_in = 5; val_rm_in = 3; sr_in = 4'b0000; dst_in = 5;
    run_single(mk(32'h1, 4'b0100, 32'h3, 32'h0, 4'd5, 4'b0000));

    clear_inputs();
    ex_command = 4'b0011; val_rn_in = 32'hFFFF_FFFF; imm = 1; imm_val = 0; sr_in = 4'b0100;
    run_single(mk(32'h0, 4'b1100, 32'h0, 32'h0, 4'd0, 4'b0000));

    clear_inputs();
    ex_command = 4'b1000; val_rn_in = 32'hF0; imm = 1; imm_val = 32'hFF; mem_write_in = 1;
    run_single(mk(32'h0F, 4'b0000, 32'h0, 32'h0, 4'd0, 4'b0100));

    clear_inputs();
    ex_command = 4'b1001; imm = 1; imm_val = 0; mem_read_in = 1;
    run_single(mk(32'hFFFF_FFFF, 4'b0010, 32'h0, 32'h0, 4'd0, 4'b1000));

    clear_inputs();
    ex_command = 4'b1100; val_rn_in = 9; imm = 1; imm_val = 7; sr_in = 4'b0110;
    run_single(mk(32'h0, 4'b1100, 32'h0, 32'h0, 4'd0, 4'b0000));

    // Branch: 0x100 + sext(0xFFFFFC) = 0xFC
    clear_inputs();
    ex_command = 4'b0001; imm = 1; imm_val = 32'h1234; pc_in = 32'h100;
    signed_immediate = 24'hFFFFFC; b_in = 1; dst_in = 4'hF;
    run_single(mk(32'h1234, 4'b0000, 32'h0, 32'hFC, 4'hF, 4'b0001));

    clear_inputs();
    tick();
    check("bubble_hold_res", alu_res, 32'h1234);
    check("bubble_clear_ctrl", {27'd0, out_valid, mem_read_out, mem_write_out, wb_en_out, b_out},
          32'd0);

    // MLA 7*6+3 with Rm from WB
    clear_inputs();
    ex_command = 4'b1011; val_rn_in = 7; val_rm_in = 99; wb_stage_val = 6; sel_src2 = 2'b10;
    val_ra_in = 3; sr_in = 4'b0101; dst_in = 7; wb_en_in = 1; pc_in = 32'h40;
    signed_immediate = 24'h10;
    run_mul(mk(32'd45, 4'b0101, 32'd6, 32'h50, 4'd7, 4'b0010), 16);

    clear_inputs();
    ex_command = 4'b1010; val_rn_in = 32'h1_0000; imm = 1; imm_val = 32'h1_0000;
    val_rm_in = 32'h55; sr_in = 4'b0111; dst_in = 2;
    run_mul(mk(32'h0, 4'b1101, 32'h55, 32'h0, 4'd2, 4'b0000), 16);

    // Flush mid-multiply: no result, stall drops at once
    clear_inputs();
    ex_command = 4'b1010; val_rn_in = 3; val_rm_in = 4; wb_en_in = 1;
    in_valid = 1;
    repeat (5) tick();
    flush = 1;
    #1;
    check("flush_stall_same_cycle", {31'd0, stall}, 32'd0);
    tick();
    flush = 0; in_valid = 0;
    #1;
    check("flush_idle_stall", {31'd0, stall}, 32'd0);
    repeat (3) tick();
    check("flush_no_valid", {31'd0, out_valid}, 32'd0);

    // Reset mid-MLA
    clear_inputs();
    ex_command = 4'b1011; val_rn_in = 7; val_rm_in = 6; val_ra_in = 3; wb_en_in = 1;
    in_valid = 1;
    repeat (3) tick();
    in_valid = 0;
    rst = 0;
    tick(); tick();
    rst = 1;
    #1;
    check("midmul_reset_data", alu_res | val_rm_out | branch_address, 32'd0);
    check("midmul_reset_ctrl",
          {24'd0, sr_out, out_valid, stall, wb_en_out, dst_out == 4'd0 ? 1'b0 : 1'b1}, 32'd0);

    clear_inputs();
    ex_command = 4'b0010; val_rn_in = 2; imm = 1; imm_val = 3; dst_in = 1; wb_en_in = 1;
    run_single(mk(32'd5, 4'b0000, 32'h0, 32'h0, 4'd1, 4'b0010));

    // One bit per cycle: stall spans 32 cycles
    clear_inputs();
    ex_command = 4'b1011; val_rn_in = 7; wb_stage_val = 6; sel_src2 = 2'b10; val_ra_in = 3;
    in_valid1 = 1;
    #1;
    n = 0;
    while (stall1 && n < 200) begin
      n++;
      tick();
    end
    check("mul1_stall_cycles", n, 32);
    tick();
    in_valid1 = 0;
    check("mul1_result", alu_res1, 32'd45);
    check("mul1_valid", {31'd0, out_valid1}, 32'd1);
    tick();
    check("mul1_valid_one_cycle", {31'd0, out_valid1}, 32'd0);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
